// File: rtl/wb_mult_initiator_pkg.sv
// wb_mult_initiator_pkg
//   Shared definitions for the Wishbone multiplier initiator: FSM state
//   encoding, register offsets inside one multiplier window, and the default
//   register-file addresses.
package wb_mult_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_V,
    ST_RD_L,
    ST_RD_H,
    ST_RSP
  } wbm_state_e;

  // Register offsets relative to a multiplier base address
  localparam int unsigned OFF_A  = 0;
  localparam int unsigned OFF_B  = 1;
  localparam int unsigned OFF_CL = 2;
  localparam int unsigned OFF_CH = 3;

  // Default register-file addresses
  localparam logic [6:0] DEF_VALID_ADR  = 7'h2;
  localparam logic [6:0] DEF_MULT1_BASE = 7'h4;
  localparam logic [6:0] DEF_MULT2_BASE = 7'h8;

  // Valid-register write pattern: bit0 starts multiplier 1, bit1 multiplier 2
  function automatic logic [1:0] valid_bits(input logic sel);
    return {sel, ~sel};
  endfunction

endpackage

// File: rtl/wb_access_timer.sv
// wb_access_timer
//   Per-access ACK timeout counter.
//   Ports:
//     clk_i      - clock
//     rst_i      - asynchronous active-high reset
//     inc_i      - count one cycle of strobe without acknowledge
//     clr_i      - restart the count (has priority over inc_i)
//     expired_o  - count has reached TIMEOUT-1
module wb_access_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/wb_mult_initiator.sv
// wb_mult_initiator
//   Wishbone initiator that runs one full multiply per command: write A,
//   write B, write the valid bit, read C_L, read C_H, then present the
//   64-bit product on the response port. One transaction outstanding.
//   Ports:
//     WBs_CLK_i / WBs_RST_i       - clock, asynchronous active-high reset
//     cmd_valid_i / cmd_ready_o   - command handshake (ready only in IDLE)
//     cmd_sel_i, cmd_a_i, cmd_b_i - multiplier select and operands
//     rsp_valid_o / rsp_ready_i   - response handshake
//     rsp_c_o, rsp_err_o          - product and timeout flag
//     WBm_*                       - Wishbone master signals (all registered)
module wb_mult_initiator
  import wb_mult_initiator_pkg::*;
#(
  parameter int unsigned          ADDRWIDTH      = 7,
  parameter int unsigned          DATAWIDTH      = 32,
  parameter int unsigned          TIMEOUT        = 16,
  parameter logic [ADDRWIDTH-1:0] MULT_VALID_ADR = DEF_VALID_ADR,
  parameter logic [ADDRWIDTH-1:0] MULT1_BASE_ADR = DEF_MULT1_BASE,
  parameter logic [ADDRWIDTH-1:0] MULT2_BASE_ADR = DEF_MULT2_BASE
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_sel_i,
  input  logic [31:0]          cmd_a_i,
  input  logic [31:0]          cmd_b_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [63:0]          rsp_c_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);

  wbm_state_e           state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [ADDRWIDTH-1:0] adr_q, adr_d;
  logic [DATAWIDTH-1:0] dat_q, dat_d;
  logic                 sel_q, sel_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          b_q, b_d;
  logic [31:0]          c_lo_q, c_lo_d;
  logic [31:0]          c_hi_q, c_hi_d;
  logic                 err_q, err_d;

  logic tmr_inc;
  logic tmr_clr;
  logic tmr_expired;
  logic acked;

  function automatic logic [ADDRWIDTH-1:0] base_adr(input logic sel);
    return sel ? MULT2_BASE_ADR : MULT1_BASE_ADR;
  endfunction

  wb_access_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (WBs_CLK_i),
    .rst_i     (WBs_RST_i),
    .inc_i     (tmr_inc),
    .clr_i     (tmr_clr),
    .expired_o (tmr_expired)
  );

  // ACK only counts while our strobe is up
  assign acked = stb_q & WBm_ACK_i;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    c_lo_d  = c_lo_q;
    c_hi_d  = c_hi_q;
    err_d   = err_q;
    tmr_inc = 1'b0;
    tmr_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          sel_d   = cmd_sel_i;
          a_d     = cmd_a_i;
          b_d     = cmd_b_i;
          tmr_clr = 1'b1;
          state_d = ST_WR_A;
          // First access is launched from the captured command so STB rises
          // on the cycle after acceptance
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = base_adr(cmd_sel_i) + ADDRWIDTH'(OFF_A);
          dat_d   = DATAWIDTH'(cmd_a_i);
        end
      end

      ST_WR_A, ST_WR_B, ST_WR_V, ST_RD_L, ST_RD_H: begin
        if (acked) begin
          // ACK wins over a timeout firing in the same cycle
          tmr_clr = 1'b1;
          unique case (state_q)
            ST_WR_A: begin
              state_d = ST_WR_B;
              adr_d   = base_adr(sel_q) + ADDRWIDTH'(OFF_B);
              dat_d   = DATAWIDTH'(b_q);
            end
            ST_WR_B: begin
              state_d    = ST_WR_V;
              adr_d      = MULT_VALID_ADR;
              dat_d      = '0;
              dat_d[1:0] = valid_bits(sel_q);
            end
            ST_WR_V: begin
              state_d = ST_RD_L;
              we_d    = 1'b0;
              adr_d   = base_adr(sel_q) + ADDRWIDTH'(OFF_CL);
              dat_d   = '0;
            end
            ST_RD_L: begin
              state_d = ST_RD_H;
              c_lo_d  = WBm_DAT_i[31:0];
              adr_d   = base_adr(sel_q) + ADDRWIDTH'(OFF_CH);
            end
            default: begin
              state_d = ST_RSP;
              c_hi_d  = WBm_DAT_i[31:0];
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
            end
          endcase
        end else if (stb_q) begin
          if (tmr_expired) begin
            state_d = ST_RSP;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            err_d   = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end

      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
          c_lo_d  = '0;
          c_hi_d  = '0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_lo_q  <= '0;
      c_hi_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_lo_q  <= c_lo_d;
      c_hi_q  <= c_hi_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign rsp_valid_o    = (state_q == ST_RSP);
  assign rsp_c_o        = {c_hi_q, c_lo_q};
  assign rsp_err_o      = err_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = stb_q;
  assign WBm_WE_o       = we_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_DAT_o      = dat_q;
  assign WBm_BYTE_STB_o = 4'hF;

endmodule

// File: tb/tb_wb_mult_initiator.sv
module tb_wb_mult_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_sel = 1'b0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_c;
  logic        rsp_err;
  logic [6:0]  adr;
  logic        cyc, stb, we;
  logic [3:0]  bsel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_mult_initiator #(
    .ADDRWIDTH (7),
    .DATAWIDTH (32),
    .TIMEOUT   (16)
  ) dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_sel_i      (cmd_sel),
    .cmd_a_i        (cmd_a),
    .cmd_b_i        (cmd_b),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_c_o        (rsp_c),
    .rsp_err_o      (rsp_err),
    .WBm_ADR_o      (adr),
    .WBm_CYC_o      (cyc),
    .WBm_STB_o      (stb),
    .WBm_WE_o       (we),
    .WBm_BYTE_STB_o (bsel),
    .WBm_DAT_o      (dat_o),
    .WBm_DAT_i      (dat_i),
    .WBm_ACK_i      (ack)
  );

  // ---------------- client model ----------------
  int         lat = 1;
  logic       blk_en = 1'b0;
  logic [6:0] blk_adr = 7'h5;
  int         wcnt;
  logic [31:0] cregs [0:127];
  logic [63:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (ack) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (cyc && stb && !(blk_en && adr == blk_adr)) begin
      if (wcnt + 1 >= lat) begin
        ack  <= 1'b1;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  always_ff @(posedge clk) begin
    if (cyc && stb && ack && we) cregs[adr] <= dat_o;
  end

  always_comb begin
    prod  = 64'(cregs[{adr[6:2], 2'b00}]) * 64'(cregs[{adr[6:2], 2'b01}]);
    dat_i = '0;
    if (adr[1:0] == 2'd2) dat_i = prod[31:0];
    else if (adr[1:0] == 2'd3) dat_i = prod[63:32];
  end

  // ---------------- bus access log ----------------
  typedef struct packed {
    logic        we;
    logic [6:0]  adr;
    logic [31:0] dat;
  } acc_t;
  acc_t log_q[$];

  always @(posedge clk) begin
    if (!rst && cyc && stb && ack) log_q.push_back({we, adr, we ? dat_o : 32'h0});
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_c;
  } vec_t;

  task automatic check_log(input vec_t v);
    acc_t       e [5];
    logic [6:0] base;
    base = v.sel ? 7'h8 : 7'h4;
    e[0] = {1'b1, base,         v.a};
    e[1] = {1'b1, base + 7'd1,  v.b};
    e[2] = {1'b1, 7'h2,         v.sel ? 32'h2 : 32'h1};
    e[3] = {1'b0, base + 7'd2,  32'h0};
    e[4] = {1'b0, base + 7'd3,  32'h0};
    check("access_count", 64'(log_q.size()), 64'd5);
    if (log_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("access%0d", i), 64'(log_q[i]), 64'(e[i]));
    end
  endtask

  task automatic run_vec(input vec_t v, input bit chk_lat);
    int n;
    log_q.delete();
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_sel = v.sel; cmd_a = v.a; cmd_b = v.b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    check("stb_cycle1", 64'(stb), 64'd1);
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", 64'(rsp_valid), 64'd1);
    if (chk_lat) check("rsp_latency", 64'(n), 64'd11);
    check("rsp_c", rsp_c, v.exp_c);
    check("rsp_err", 64'(rsp_err), 64'd0);
    check("cyc_low_rsp", 64'(cyc), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_clr", 64'(rsp_valid), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("rsp_c_clr", rsp_c, 64'd0);
    check_log(v);
  endtask

  vec_t vecs [5];

  initial begin
    int   n, stbn, acc, rsps;
    logic ok, spurious;
    logic [63:0] c0;

    vecs[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};

    // reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_outputs", {rsp_valid, rsp_err, cyc, stb, we, adr, dat_o}, 64'd0);
    check("rst_rsp_c", rsp_c, 64'd0);
    check("rst_byte_stb", 64'(bsel), 64'hF);

    // table-driven vectors with registered-ACK client
    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1);

    // timeout on WR_B
    blk_en = 1'b1; blk_adr = 7'h5;
    log_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_a = 32'h11; cmd_b = 32'h22;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1; stbn = 0;
    while (!rsp_valid && n < 400) begin
      if (stb && adr == 7'h5) stbn++;
      @(negedge clk);
      n++;
    end
    check("to_rsp_seen", 64'(rsp_valid), 64'd1);
    check("to_stb_cycles", 64'(stbn), 64'd16);
    check("to_rsp_cycle", 64'(n), 64'd19);
    check("to_err", 64'(rsp_err), 64'd1);
    check("to_c", rsp_c, 64'd0);
    check("to_cyc", 64'(cyc), 64'd0);
    check("to_accesses", 64'(log_q.size()), 64'd1);
    blk_en = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("to_err_clr", 64'(rsp_err), 64'd0);
    run_vec(vecs[1], 1'b1);

    // response stall: 20 cycles with rsp_ready low while cmd_valid is held
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_a = 32'h0001_0000; cmd_b = 32'h0001_0000;
    @(posedge clk);
    @(negedge clk);
    cmd_a = 32'h5; cmd_b = 32'h7;
    n = 1;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    c0 = rsp_c;
    check("stall_c", c0, 64'h0000_0001_0000_0000);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_c == c0 && !cmd_ready && !cyc && !stb)) ok = 1'b0;
    end
    check("stall_stable", 64'(ok), 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check("stall_release", 64'(rsp_valid), 64'd0);
    check("stall_ready", 64'(cmd_ready), 64'd1);

    // reset during RD_L
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_a = 32'h5; cmd_b = 32'h6;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!(stb && adr == 7'h6) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rd_l_reached", 64'(stb && adr == 7'h6), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_bus", {cyc, stb, rsp_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || cyc) spurious = 1'b1;
    end
    check("rst_no_spurious", 64'(spurious), 64'd0);

    // 3-cycle ACK latency, cmd_valid held, rsp_ready held
    lat = 3;
    log_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = 1'b1; cmd_a = 32'd7; cmd_b = 32'd9;
    rsp_ready = 1'b1;
    acc = 0; rsps = 0; n = 0;
    while (rsps < 4 && n < 2000) begin
      if (cmd_ready && cmd_valid) acc++;
      if (rsp_valid) begin
        rsps++;
        check("lat3_c", rsp_c, 64'd63);
        check("lat3_err", 64'(rsp_err), 64'd0);
        if (rsps == 4) cmd_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("lat3_rsps", 64'(rsps), 64'd4);
    check("lat3_accepts", 64'(acc), 64'd4);
    check("lat3_accesses", 64'(log_q.size()), 64'd20);
    check("lat3_idle", 64'(cmd_ready), 64'd1);
    lat = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
